// File: rtl/fb_scanout_if.sv
// Framebuffer read port between the scanout engine and the framebuffer BRAM.
// The scanout side drives address/enable; the memory returns the colour index.
interface fb_scanout_if #(
  parameter int ADDRW = 19
);
  logic [ADDRW-1:0] fb_addr;
  logic             fb_en;
  logic [3:0]       fb_data;

  modport master (
    output fb_addr,
    output fb_en,
    input  fb_data
  );

  modport slave (
    input  fb_addr,
    input  fb_en,
    output fb_data
  );
endinterface

// File: rtl/fb_scanout.sv
// Raster-order framebuffer scanout with 16-entry palette to RGB444.
// Optional double-buffer select/handshake when FB_SWAP_EN is defined.
module fb_scanout #(
  parameter int         CORDW    = 10,
  parameter int         H_RES    = 800,
  parameter int         V_RES    = 480,
  parameter int         HALF_RES = 1,
  parameter int         ADDRW    = 19,
  parameter int         RD_LAT   = 1,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync_in,
  input  logic             vsync_in,
  fb_scanout_if.master     fb,
  input  logic             pal_we,
  input  logic [3:0]       pal_addr,
  input  logic [11:0]      pal_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             fb_sel,
  output logic [11:0]      rgb,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  localparam int DEPTH = (HALF_RES != 0) ? H_RES * V_RES / 2
                                         : H_RES * V_RES;
  localparam int NST = RD_LAT + 1;
  localparam logic [ADDRW:0]   DEPTH_W = (ADDRW+1)'(DEPTH);
  localparam logic [CORDW-1:0] V_END   = CORDW'(V_RES);

  // One spare bit lets the counter park at DEPTH without wrapping.
  logic [ADDRW:0] cnt;
  logic           phase;
  logic           synced;
  logic           act;
  logic           in_rng;
  logic [NST-1:0] de_d;
  logic [NST-1:0] hs_d;
  logic [NST-1:0] vs_d;
  logic [NST-1:0] oor_d;
  logic [11:0]    pal [16];

  // After a reset nothing is fetched until a vertical blank realigns cnt.
  assign act    = de && synced;
  assign in_rng = cnt < DEPTH_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      phase      <= 1'b0;
      synced     <= 1'b0;
      fb.fb_en   <= 1'b0;
      fb.fb_addr <= '0;
    end else if (act) begin
      fb.fb_en   <= in_rng;
      fb.fb_addr <= cnt[ADDRW-1:0];
      phase      <= ~phase;
      if (in_rng && ((HALF_RES == 0) || phase))
        cnt <= cnt + 1'b1;
    end else begin
      fb.fb_en <= 1'b0;
      phase    <= 1'b0;
      if (!de && (sy >= V_END)) begin
        cnt    <= '0;
        synced <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_d  <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      oor_d <= '0;
    end else begin
      de_d  <= {de_d[NST-2:0], act};
      hs_d  <= {hs_d[NST-2:0], hsync_in};
      vs_d  <= {vs_d[NST-2:0], vsync_in};
      oor_d <= {oor_d[NST-2:0], act && !in_rng};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= BG_COLOR;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      de_out    <= de_d[NST-1];
      hsync_out <= hs_d[NST-1];
      vsync_out <= vs_d[NST-1];
      rgb       <= (de_d[NST-1] && !oor_d[NST-1]) ? pal[fb.fb_data]
                                                  : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

`ifdef FB_SWAP_EN
  logic pend;
  logic sel_q;
  logic ack_q;
  logic at_pt;
  logic at_pt_q;
  logic take;

  assign at_pt = (sy == V_END) && (sx == '0);
  assign take  = at_pt && !at_pt_q && (pend || swap_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      at_pt_q <= 1'b0;
    end else begin
      at_pt_q <= at_pt;
      ack_q   <= take;
      pend    <= take ? 1'b0 : (pend || swap_req);
      if (take)
        sel_q <= ~sel_q;
    end
  end

  assign swap_ack = ack_q;
  assign fb_sel   = sel_q;
`else
  logic swap_unused;

  assign swap_unused = ^{swap_req, sx};
  assign swap_ack    = 1'b0;
  assign fb_sel      = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: three configurations driven by one small raster,
// compared against a coordinate-based reference model with random palette/data.
module tb_fb_scanout;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HT = 22;
  localparam int VT = 11;
  localparam int AW = 8;
  localparam logic [11:0] BG = 12'h000;

  typedef struct {
    logic act;
    logic hs;
    logic vs;
    int   a;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        de;
  logic        hs;
  logic        vs;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic        swap_req;
  bit          run;
  int          x, y, f;
  int          checks;
  int          failures;
  int          acks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT   = g + 1;
    localparam int HALF  = (g == 1) ? 1 : 0;
    localparam int DEPTH = (HALF != 0) ? H * V / 2 : H * V;

    fb_scanout_if #(.ADDRW(AW)) fb ();

    logic [11:0] rgb;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;
    logic        ack;
    logic        sel;

    fb_scanout #(
      .CORDW(10), .H_RES(H), .V_RES(V), .HALF_RES(HALF),
      .ADDRW(AW), .RD_LAT(LAT), .BG_COLOR(BG)
    ) dut (
      .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de),
      .hsync_in(hs), .vsync_in(vs), .fb(fb),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .swap_req(swap_req), .swap_ack(ack), .fb_sel(sel),
      .rgb(rgb), .de_out(de_o), .hsync_out(hs_o), .vsync_out(vs_o)
    );

    logic [3:0] mem [256];
    logic [3:0] rq [1:LAT];

    initial
      for (int i = 0; i < 256; i++)
        mem[i] = 4'($urandom);

    always @(posedge clk) begin
      rq[1] <= fb.fb_en ? mem[fb.fb_addr] : 4'd0;
      for (int i = 2; i <= LAT; i++)
        rq[i] <= rq[i-1];
    end

    assign fb.fb_data = rq[LAT];

    ent_t        q[$];
    ent_t        p;
    logic [11:0] pm [16];
    bit          synced;
    bit          mact;
    int          a;
    logic [11:0] e_rgb = BG;
    logic        e_de = 1'b0;
    logic        e_hs = 1'b0;
    logic        e_vs = 1'b0;
    logic        e_en = 1'b0;
    logic        e_ca = 1'b0;
    int          e_addr = 0;
    bit          pt_prev;
    bit          pend;
    bit          pt;
    logic        e_sel = 1'b0;
    logic        e_ack = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        synced = 1'b0;
        for (int i = 0; i < 16; i++)
          pm[i] = {3{4'(i)}};
        e_rgb  = BG;
        e_de   = 1'b0;
        e_hs   = 1'b0;
        e_vs   = 1'b0;
        e_en   = 1'b0;
        e_ca   = 1'b1;
        e_addr = 0;
        pt_prev = 1'b0;
        pend    = 1'b0;
        e_sel   = 1'b0;
        e_ack   = 1'b0;
      end else begin
        a = (HALF != 0) ? int'(sy) * (H / 2) + int'(sx) / 2
                        : int'(sy) * H + int'(sx);
        mact = de && synced;
        if (!de && int'(sy) >= V)
          synced = 1'b1;
        e_en   = mact && (a < DEPTH);
        e_ca   = e_en;
        e_addr = a;
        q.push_back(ent_t'{mact, hs, vs, a});
        if (q.size() > LAT + 1) begin
          p     = q.pop_front();
          e_de  = p.act;
          e_hs  = p.hs;
          e_vs  = p.vs;
          e_rgb = (p.act && p.a < DEPTH) ? pm[mem[p.a]] : BG;
        end
        if (pal_we)
          pm[pal_addr] = pal_data;
`ifdef FB_SWAP_EN
        pt    = (int'(sy) == V) && (sx == 10'd0);
        e_ack = pt && !pt_prev && (pend || swap_req);
        pt_prev = pt;
        if (e_ack)
          e_sel = !e_sel;
        pend = !e_ack && (pend || swap_req);
`endif
      end
    end

    always @(negedge clk) begin
      if (run) begin
        chk($sformatf("u%0d.rgb", g), 32'(rgb), 32'(e_rgb));
        chk($sformatf("u%0d.de_out", g), 32'(de_o), 32'(e_de));
        chk($sformatf("u%0d.hsync_out", g), 32'(hs_o), 32'(e_hs));
        chk($sformatf("u%0d.vsync_out", g), 32'(vs_o), 32'(e_vs));
        chk($sformatf("u%0d.fb_en", g), 32'(fb.fb_en), 32'(e_en));
        if (e_ca)
          chk($sformatf("u%0d.fb_addr", g), 32'(fb.fb_addr), 32'(e_addr));
        chk($sformatf("u%0d.fb_sel", g), 32'(sel), 32'(e_sel));
        chk($sformatf("u%0d.swap_ack", g), 32'(ack), 32'(e_ack));
      end
    end
  end

  always @(negedge clk)
    if (run && f >= 6 && f <= 8 && u[0].ack)
      acks++;

  task automatic step(input bit force_rst);
    @(posedge clk);
    #1;
    if (x == HT - 1) begin
      x = 0;
      if (y == VT - 1) begin
        y = 0;
        f++;
      end else begin
        y++;
      end
    end else begin
      x++;
    end
    sx = 10'(x);
    sy = 10'(y);
    de = (x < H) && ((y < V) || (f == 2 && y == V));
    hs = (x >= 18) && (x < 20);
    vs = (y == 9);
    rst = force_rst || (f == 3 && x == 8 && y == 4);
    pal_we   = (f >= 2) && ($urandom_range(0, 11) == 0);
    pal_addr = 4'($urandom);
    pal_data = 12'($urandom);
    swap_req = (f == 5 && x == 3 && y == 2) || (f == 6) || (f == 7)
            || (f == 8 && (y < V || (y == V && x == 0)));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acks     = 0;
    run      = 1'b0;
    x  = 0;
    y  = V + 1;
    f  = 0;
    sx = 10'(x);
    sy = 10'(y);
    de = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    rst      = 1'b1;
    pal_we   = 1'b0;
    pal_addr = 4'd0;
    pal_data = 12'd0;
    swap_req = 1'b0;
    step(1'b1);
    run = 1'b1;
    step(1'b1);
    step(1'b1);
    while (f < 10)
      step(1'b0);
    @(negedge clk);
`ifdef FB_SWAP_EN
    chk("swap_count", 32'(acks), 32'd3);
`else
    chk("swap_count", 32'(acks), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
